dm_bus_ctrl: RTL and testbench
==============================

// Module: dm_bus_ctrl
// PURPOSE
//  Data-memory bus controller between the single-cycle CPU data port and a word-wide data SRAM with variable latency.
//  - Converts CPU store width (word/half/byte) into byte enables and lane-replicated write data.
//  - Runs a req/ack handshake with the SRAM.
//  - Holds the CPU with stall until the access completes.
//  - Flags misaligned stores and SRAM timeouts.
// PARAMETERS
//  AW       10   SRAM word-address width; mem_addr = cpu_addr[AW+1:2]
//  TIMEOUT  16   max BUSY cycles waiting for mem_ack before abort (>=2)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset; synchronous, active-low
//  cpu_addr   in   32  byte address (CPU ALU output)
//  cpu_wdata  in   32  store data (CPU rt data)
//  cpu_we     in   1   store request (CPU MemWrite)
//  cpu_re     in   1   load request (decoded at top level)
//  cpu_sh     in   1   halfword store (CPU DM_SH)
//  cpu_sb     in   1   byte store (CPU DM_SB); priority over cpu_sh
//  cpu_rdata  out  32  load data to CPU write-back mux
//  stall      out  1   freeze PC/RF write while high
//  bus_err    out  1   sticky error: misaligned store or timeout
//  mem_req    out  1   SRAM request, registered
//  mem_we     out  1   SRAM write qualifier, registered
//  mem_addr   out  AW  SRAM word address, registered
//  mem_be     out  4   byte enables, registered; bit i = byte i (little-endian)
//  mem_wdata  out  32  lane-replicated write data, registered
//  mem_ack    in   1   SRAM completion, one cycle per request
//  mem_rdata  in   32  SRAM read data, valid with mem_ack
// BEHAVIOUR
//  Reset (rst==0 at edge)
//   - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
//   - cpu_rdata=0, bus_err=0, timeout counter=0.
//  Reset mid-access
//   - Abandons the access. mem_req is low from the next cycle.
//   - A late mem_ack is ignored.
//  States
//   IDLE
//    - access = cpu_we|cpu_re. stall = access (combinational).
//    - cpu_we wins if both are high: the access is a store.
//    - Aligned access: latch addr/be/wdata/we; mem_req<=1; go BUSY.
//    - Misaligned store (SH with addr[0]=1, or SW with addr[1:0]!=0): no SRAM request; bus_err<=1; go DONE.
//   BUSY
//    - stall=1; mem_req held with all outputs stable; counter increments each cycle.
//    - On mem_ack: mem_req<=0; cpu_rdata<=mem_rdata if load; go DONE.
//    - If counter==TIMEOUT-1 and no ack: mem_req<=0; cpu_rdata<=0; bus_err<=1; go DONE.
//   DONE
//    - stall=0, so the CPU retires the instruction at this edge.
//    - Unconditionally go IDLE; counter<=0.
//  Latency and handshake
//   - Load/store with ack in the first BUSY cycle: stall high 2 cycles, retire in cycle 3.
//   - Each extra wait cycle adds one stall cycle.
//   - mem_ack outside BUSY is ignored.
//   - mem_req never drops before ack or timeout.
//  Lane steering
//   - SB: be = 4'b0001<<addr[1:0]; wdata = {4{wd[7:0]}}.
//   - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wd[15:0]}}.
//   - SW: be = 4'b1111; wdata = wd.
//   - Load: be = 4'b1111; addr[1:0] ignored; full word returned.
//   - cpu_rdata is held between loads; it is updated only by load completion or timeout.
//  Boundaries
//   - Address bits above AW+1 are ignored (wrap within SRAM).
//   - bus_err clears only on reset.
// STRUCTURE
//  dm_pkg
//   - state enum: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
//   - BE_WORD/BE_HALF_LO/BE_HALF_HI/BE_BYTE0 constants.
//  dm_lane_steer (combinational sub-module)
//   - in: addr[1:0], sh, sb, wd.
//   - out: be, wdata, misaligned.
//  Top: FSM, timeout counter, output registers.
// TESTING
//  1. SW 0x12345678 @0x0000_0010, ack 1 cycle after req
//     -> mem_addr=4, be=1111, wdata=0x12345678; stall 2 cycles; err=0.
//  2. SB 0x000000AB @0x13
//     -> be=1000, wdata=0xABABABAB; SH 0xBEEF @0x12 -> be=1100, wdata=0xBEEFBEEF.
//  3. LW @0x20, ack after 3 wait cycles, rdata=0xCAFEF00D
//     -> stall 5 cycles; cpu_rdata=0xCAFEF00D in DONE.
//  4. SH @0x11 (misaligned)
//     -> mem_req never asserts; bus_err=1; stall 1 cycle; next access still serviced.
//  5. LW with SRAM never acking, TIMEOUT=16
//     -> mem_req high exactly 16 cycles; cpu_rdata=0; bus_err=1; FSM returns IDLE.
//  6. rst=0 during BUSY, then ack the next cycle
//     -> outputs reset values; ack ignored; stall=0 with no CPU access.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and byte-enable constants for the data-memory bus controller.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

endpackage

// File: rtl/dm_lane_steer.sv
// Store-width steering: byte enables, lane-replicated write data, alignment check.
module dm_lane_steer
  import dm_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic        i_sh,
  input  logic        i_sb,
  input  logic [31:0] i_wd,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  // Byte stores have priority over halfword stores and can never be misaligned.
  always_comb begin
    o_be         = BE_WORD;
    o_wdata      = i_wd;
    o_misaligned = 1'b0;
    if (i_sb) begin
      o_be    = BE_BYTE0 << i_addr;
      o_wdata = {4{i_wd[7:0]}};
    end else if (i_sh) begin
      o_be         = i_addr[1] ? BE_HALF_HI : BE_HALF_LO;
      o_wdata      = {2{i_wd[15:0]}};
      o_misaligned = i_addr[0];
    end else begin
      o_misaligned = (i_addr != 2'b00);
    end
  end

endmodule

// File: rtl/dm_bus_ctrl.sv
// Data-memory bus controller: stalls the CPU across a req/ack SRAM access with timeout.
// Handshake: mem_req rises with all mem_* outputs stable and holds until the cycle mem_ack is seen or TIMEOUT expires.
module dm_bus_ctrl
  import dm_pkg::*;
#(
  parameter int AW      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic          cpu_sh,
  input  logic          cpu_sb,
  output logic [31:0]   cpu_rdata,
  output logic          stall,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  dm_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_cpu_rdata;
  logic          r_bus_err;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [3:0]    r_mem_be;
  logic [31:0]   r_mem_wdata;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_steer_mis;
  logic          w_access;
  logic          w_mis;
  logic          w_timeout;
  logic          w_stall;
  logic          w_unused_addr;

  dm_lane_steer u_steer (
    .i_addr       (cpu_addr[1:0]),
    .i_sh         (cpu_sh),
    .i_sb         (cpu_sb),
    .i_wd         (cpu_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_steer_mis)
  );

  assign w_access      = cpu_we | cpu_re;
  assign w_mis         = cpu_we & w_steer_mis;
  assign w_timeout     = (r_cnt == CNT_LAST);
  assign w_unused_addr = ^cpu_addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_access;
        if (w_access) w_state_nxt = w_mis ? DONE : BUSY;
      end
      BUSY: begin
        w_stall = 1'b1;
        if (mem_ack || w_timeout) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_bus_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            if (w_mis) begin
              r_bus_err <= 1'b1;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= cpu_we;
              r_mem_addr  <= cpu_addr[AW+1:2];
              r_mem_be    <= cpu_we ? w_be : BE_WORD;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) r_cpu_rdata <= mem_rdata;
          end else if (w_timeout) begin
            r_mem_req   <= 1'b0;
            r_cpu_rdata <= '0;
            r_bus_err   <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign stall     = w_stall;
  assign bus_err   = r_bus_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Self-checking bench for dm_bus_ctrl: SRAM request scoreboard plus per-access stall/rdata/error checks.
module tb_dm_bus_ctrl;

  localparam int AW      = 10;
  localparam int TIMEOUT = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          cpu_we = 1'b0;
  logic          cpu_re = 1'b0;
  logic          cpu_sh = 1'b0;
  logic          cpu_sb = 1'b0;
  logic [31:0]   cpu_rdata;
  logic          stall;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic [1:0]    dbg_state;

  dm_bus_ctrl #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_sh(cpu_sh), .cpu_sb(cpu_sb), .cpu_rdata(cpu_rdata), .stall(stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: {we, addr, be, wdata}
  logic [46:0] exp_q[$];
  logic [31:0] rd_q[$];
  logic        err_exp  = 1'b0;
  logic [31:0] last_rd  = '0;
  logic        prev_req = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM-side monitor: each new request is compared against the oldest expectation
  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        check("req_unexpected", 1, 0);
      end else begin
        logic [46:0] e;
        e = exp_q.pop_front();
        check("req_hdr", {mem_we, mem_addr, mem_be}, e[46:32]);
        if (e[46]) check("req_wdata", mem_wdata, e[31:0]);
      end
    end
    prev_req = mem_req;
  end

  // drives one CPU access; wait_n = BUSY cycles before ack, -1 = SRAM never acks
  task automatic cpu_access(input logic we, input logic re, input logic sh, input logic sb,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int wait_n, input logic [31:0] rd);
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdx;
    int          stalls, reqs, busy_idx, exp_stall, exp_req;
    bit          done;
    mis = 1'b0;
    be  = 4'b1111;
    wdx = wd;
    if (we) begin
      if (sb) begin
        be  = 4'b0001 << addr[1:0];
        wdx = {4{wd[7:0]}};
      end else if (sh) begin
        be  = addr[1] ? 4'b1100 : 4'b0011;
        wdx = {2{wd[15:0]}};
        mis = addr[0];
      end else begin
        mis = (addr[1:0] != 2'b00);
      end
    end
    if (mis) begin
      err_exp   = 1'b1;
      exp_stall = 1;
      exp_req   = 0;
    end else begin
      exp_q.push_back({we, addr[AW+1:2], be, wdx});
      if (wait_n < 0) begin
        exp_stall = TIMEOUT + 1;
        exp_req   = TIMEOUT;
        err_exp   = 1'b1;
        last_rd   = '0;
      end else begin
        exp_stall = wait_n + 2;
        exp_req   = wait_n + 1;
        if (!we) last_rd = rd;
      end
    end
    rd_q.push_back(last_rd);

    cpu_we = we; cpu_re = re; cpu_sh = sh; cpu_sb = sb;
    cpu_addr = addr; cpu_wdata = wd;
    stalls = 0; reqs = 0; busy_idx = 0; done = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (mem_req) begin
        mem_ack   = (busy_idx == wait_n);
        mem_rdata = mem_ack ? rd : $urandom;
      end else begin
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
      #1;
      if (stall) stalls++;
      if (mem_req) begin
        reqs++;
        busy_idx++;
      end
      if (dbg_state == S_DONE) begin
        done = 1;
        check("rdata", cpu_rdata, rd_q.pop_front());
        check("bus_err", bus_err, err_exp);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    check("done_reached", done, 1);
    check("stall_cycles", stalls, exp_stall);
    check("req_cycles", reqs, exp_req);
    check("back_idle", dbg_state, S_IDLE);
    cpu_we = 0; cpu_re = 0; cpu_sh = 0; cpu_sb = 0;
  endtask

  initial begin
    // reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_err", bus_err, 0);
    check("rst_stall", stall, 0);
    check("rst_state", dbg_state, S_IDLE);
    @(posedge clk); #1;

    // directed cases
    cpu_access(1, 0, 0, 0, 32'h0000_0010, 32'h1234_5678, 0, '0);
    cpu_access(1, 0, 0, 1, 32'h0000_0013, 32'h0000_00AB, 1, '0);
    cpu_access(1, 0, 1, 0, 32'h0000_0012, 32'h0000_BEEF, 0, '0);
    cpu_access(0, 1, 0, 0, 32'h0000_0020, '0, 3, 32'hCAFE_F00D);
    cpu_access(1, 0, 0, 0, 32'hFFFF_F014, 32'h5555_AAAA, 2, '0);
    cpu_access(0, 1, 0, 0, 32'h0000_0023, '0, 0, 32'h0BAD_F00D);
    cpu_access(1, 1, 0, 0, 32'h0000_0030, 32'h7777_0001, 0, '0);
    cpu_access(1, 0, 1, 0, 32'h0000_0011, 32'h0000_1234, 0, '0);
    cpu_access(0, 1, 0, 0, 32'h0000_0044, '0, 1, 32'h1357_9BDF);
    cpu_access(0, 1, 0, 0, 32'h0000_0048, '0, -1, 32'h0);
    cpu_access(1, 0, 0, 0, 32'h0000_004C, 32'hA5A5_5A5A, 0, '0);

    // random mix (misaligned stores and both-request cases included)
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, w, r;
      logic        we, re, sh, sb;
      a  = $urandom;
      w  = $urandom;
      r  = $urandom;
      we = $urandom_range(0, 1);
      re = we ? logic'($urandom_range(0, 1)) : 1'b1;
      sh = $urandom_range(0, 1);
      sb = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      cpu_access(we, re, sh, sb, a, w, $urandom_range(0, 4), r);
    end

    // reset while BUSY, then a late ack
    cpu_re = 1'b1;
    cpu_addr = 32'h0000_0040;
    exp_q.push_back({1'b0, 10'h010, 4'b1111, 32'h0});
    @(posedge clk); #1;
    check("mid_busy", dbg_state, S_BUSY);
    cpu_re = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_stall", stall, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_state", dbg_state, S_IDLE);
    check("late_ack_rdata", cpu_rdata, 0);
    check("late_ack_err", bus_err, 0);
    check("late_ack_be", mem_be, 0);
    check("late_ack_req", mem_req, 0);
    err_exp = 1'b0;
    last_rd = '0;
    cpu_access(0, 1, 0, 0, 32'h0000_0050, '0, 0, 32'h2468_ACE0);

    repeat (2) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
